td4x_core: RTL and testbench
============================

# td4x_core

Parametrised next-generation TD4-class accumulator CPU core: registers A, B and OUT, a carry flag and a program counter, with combinational instruction fetch from an external ROM. Compared with the fixed 4-bit core, it has configurable data and address widths, a fetch-valid handshake so slower program memories can stall it, an output-write strobe, and a HALT instruction. It sits between the program ROM and the board I/O.

## Interface
Parameters:
- DW, 4: data and immediate width; A, B, OUT, `in` and the immediate are DW bits.
- AW, 4: PC and ROM address width; must satisfy 1 ≤ AW ≤ DW.
- RESET_PC, 0: PC value loaded by reset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  out  AW  ROM address; equals the PC register, no added logic.
- instr  in  4+DW  instruction: op = instr[DW+3:DW], im = instr[DW-1:0].
- instr_valid  in  1  instr is valid for the current address this cycle.
- in  in  DW  input port.
- out  out  DW  output port register.
- out_strobe  out  1  one-cycle pulse, registered, in the cycle after an OUT instruction executes.
- halted  out  1  core is in the HALT state.

## Operation
- Every executed instruction computes `sum = sel + im`, DW+1 bits wide:
  - sel is A, B, `in` or 0, chosen by op.
  - result = sum[DW-1:0]; c = sum[DW].
- Opcodes:
  - 0000 ADD A,Im: A←A+im.
  - 0001 MOV A,B: A←B+im.
  - 0010 IN A: A←in+im.
  - 0011 MOV A,Im: A←im.
  - 0100 MOV B,A: B←A+im.
  - 0101 ADD B,Im: B←B+im.
  - 0110 IN B: B←in+im.
  - 0111 MOV B,Im: B←im.
  - 1001 OUT B: OUT←B+im.
  - 1011 OUT Im: OUT←im.
  - 1110 JNC: PC←im[AW-1:0] if carry==0, else PC+1.
  - 1111 JMP: PC←im[AW-1:0].
  - 1000 HALT.
  - 1010, 1100, 1101: NOP, PC←PC+1.
- Carry register:
  - Loaded with c on every executed instruction of the 12 TD4 opcodes, including JNC and JMP.
  - Unchanged by NOP and HALT.
  - JNC tests the carry value from *before* the current instruction.
- Wrap rules:
  - PC+1 wraps modulo 2^AW.
  - Immediate bits above AW are ignored for jumps.
- FSM states:
  - RUN: execute when instr_valid=1. When instr_valid=0, nothing changes (PC, A, B, OUT, carry hold; out_strobe=0).
  - HALT: entered on an executed HALT. PC stays at the HALT's address; all registers hold; instr and instr_valid are ignored; halted=1. Only reset exits.
- Transitions: RUN→HALT on a valid HALT; HALT→RUN only by reset.

## Timing
- Single-cycle execution. An instruction presented with instr_valid=1 at rising edge k updates its destination, carry and PC at edge k; `address` shows the new PC after edge k.
- out_strobe is high for exactly the cycle after edge k when the instruction was OUT. Back-to-back OUTs give a continuously high strobe.
- halted rises in the cycle after the HALT edge.
- Reset values (reset high at an edge): PC=RESET_PC, A=B=OUT=0, carry=0, state=RUN, out_strobe=0, halted=0.
- Reset wins over any simultaneous instruction, including in mid-stall and in HALT.
- instr is sampled only at edges where instr_valid=1. instr may change freely while instr_valid=0.

## Structure
- Shared package `td4x_pkg`: opcode localparams (OP_ADD_A … OP_JMP, OP_HALT), the state enum (ST_RUN, ST_HALT) and the selector encoding (SEL_A, SEL_B, SEL_IN, SEL_ZERO).
- One combinational sub-module, `td4x_decode`: op and carry → sel, load_a, load_b, load_out, load_pc, upd_carry, is_halt.
- All registers and the FSM live in `td4x_core`.

## Test plan
- Reset with DW=4, RESET_PC=3 → address=3, out=0, halted=0, out_strobe=0.
- ADD A,15 after MOV A,Im 1 → A=0, carry=1. The following JNC 0x9 is not taken (address=PC+1). After ADD A,0 clears carry, JNC 0x9 → address=9.
- OUT Im 0xA with instr_valid=1 → out=0xA with a one-cycle out_strobe. Holding instr_valid=0 for 3 cycles → address, A, B and out unchanged, out_strobe=0.
- HALT at address 5 → halted=1 and address=5 held for 10 cycles despite changing instr. Reset → address=RESET_PC, halted=0.
- DW=8, AW=4: MOV A,Im 0xF0; ADD A,0x20 → A=0x10, carry=1. JMP 0x37 → address=7 (upper immediate bits ignored).
- Full 4-bit ramen-timer program with in=0101, run to completion → same out sequence as the legacy core.

Source files
------------

// File: rtl/td4x_pkg.sv
// Shared definitions for the parametrised TD4-class core: opcodes, FSM states
// and the adder operand selector.
package td4x_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
    localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
    localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
    localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;
    localparam logic [OP_W-1:0] OP_HALT   = 4'b1000;
    localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        SEL_A,
        SEL_B,
        SEL_IN,
        SEL_ZERO
    } sel_e;

endpackage

// File: rtl/td4x_decode.sv
// Instruction decoder: opcode and current carry to adder operand select and
// register load enables. Purely combinational.
module td4x_decode
    import td4x_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            carry,
    output sel_e            sel,
    output logic            load_a,
    output logic            load_b,
    output logic            load_out,
    output logic            load_pc,
    output logic            upd_carry,
    output logic            is_halt
);

    always_comb begin
        sel       = SEL_ZERO;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_out  = 1'b0;
        load_pc   = 1'b0;
        upd_carry = 1'b0;
        is_halt   = 1'b0;
        unique case (op)
            OP_ADD_A: begin
                sel = SEL_A;    load_a = 1'b1;   upd_carry = 1'b1;
            end
            OP_MOV_AB: begin
                sel = SEL_B;    load_a = 1'b1;   upd_carry = 1'b1;
            end
            OP_IN_A: begin
                sel = SEL_IN;   load_a = 1'b1;   upd_carry = 1'b1;
            end
            OP_MOV_AI: begin
                sel = SEL_ZERO; load_a = 1'b1;   upd_carry = 1'b1;
            end
            OP_MOV_BA: begin
                sel = SEL_A;    load_b = 1'b1;   upd_carry = 1'b1;
            end
            OP_ADD_B: begin
                sel = SEL_B;    load_b = 1'b1;   upd_carry = 1'b1;
            end
            OP_IN_B: begin
                sel = SEL_IN;   load_b = 1'b1;   upd_carry = 1'b1;
            end
            OP_MOV_BI: begin
                sel = SEL_ZERO; load_b = 1'b1;   upd_carry = 1'b1;
            end
            OP_OUT_B: begin
                sel = SEL_B;    load_out = 1'b1; upd_carry = 1'b1;
            end
            OP_OUT_I: begin
                sel = SEL_ZERO; load_out = 1'b1; upd_carry = 1'b1;
            end
            // JNC branches on the carry from before this instruction
            OP_JNC: begin
                sel = SEL_ZERO; load_pc = ~carry; upd_carry = 1'b1;
            end
            OP_JMP: begin
                sel = SEL_ZERO; load_pc = 1'b1;  upd_carry = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/td4x_core.sv
// TD4-class accumulator core with configurable widths, fetch-valid stall,
// output strobe and HALT. All architectural state lives here.
module td4x_core
    import td4x_pkg::*;
#(
    parameter int unsigned DW       = 4,
    parameter int unsigned AW       = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [AW-1:0]      address,
    input  logic [OP_W+DW-1:0] instr,
    input  logic               instr_valid,
    input  logic [DW-1:0]      in,
    output logic [DW-1:0]      out,
    output logic               out_strobe,
    output logic               halted
);

    localparam int unsigned SW = DW + 1;

    logic [AW-1:0]   pc;
    logic [DW-1:0]   reg_a;
    logic [DW-1:0]   reg_b;
    logic            carry;
    state_e          state;

    logic [OP_W-1:0] op;
    logic [DW-1:0]   im;
    logic [DW-1:0]   sel_val;
    logic [SW-1:0]   sum;
    logic [DW-1:0]   result;

    sel_e            sel;
    logic            load_a;
    logic            load_b;
    logic            load_out;
    logic            load_pc;
    logic            upd_carry;
    logic            is_halt;

    assign op      = instr[DW+OP_W-1:DW];
    assign im      = instr[DW-1:0];
    assign address = pc;
    assign halted  = (state == ST_HALT);

    td4x_decode u_decode (
        .op        (op),
        .carry     (carry),
        .sel       (sel),
        .load_a    (load_a),
        .load_b    (load_b),
        .load_out  (load_out),
        .load_pc   (load_pc),
        .upd_carry (upd_carry),
        .is_halt   (is_halt)
    );

    // Single adder shared by every instruction; sum[DW] is the carry out
    always_comb begin
        sel_val = '0;
        unique case (sel)
            SEL_A:    sel_val = reg_a;
            SEL_B:    sel_val = reg_b;
            SEL_IN:   sel_val = in;
            SEL_ZERO: sel_val = '0;
            default:  sel_val = '0;
        endcase
        sum    = SW'(sel_val) + SW'(im);
        result = sum[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= AW'(RESET_PC);
            reg_a      <= '0;
            reg_b      <= '0;
            out        <= '0;
            carry      <= 1'b0;
            out_strobe <= 1'b0;
            state      <= ST_RUN;
        end else begin
            out_strobe <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (instr_valid) begin
                        if (is_halt) begin
                            state <= ST_HALT;
                        end else begin
                            if (load_a)    reg_a <= result;
                            if (load_b)    reg_b <= result;
                            if (load_out)  out   <= result;
                            if (upd_carry) carry <= sum[DW];
                            // upper immediate bits beyond AW are dropped on jumps
                            pc         <= load_pc ? im[AW-1:0] : pc + AW'(1);
                            out_strobe <= load_out;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_td4x_core.sv
// Bench for td4x_core: two instances (DW=4/RESET_PC=3 and DW=8/RESET_PC=0)
// checked every cycle against an instruction-level model plus literal pins.
module tb_td4x_core;

    logic clk;

    logic        r4, v4;
    logic [7:0]  i4;
    logic [3:0]  in4;
    logic [3:0]  a4;
    logic [3:0]  o4;
    logic        s4, h4;

    logic        r8, v8;
    logic [11:0] i8;
    logic [7:0]  in8;
    logic [3:0]  a8;
    logic [7:0]  o8;
    logic        s8, h8;

    int checks;
    int errors;

    int m_pc[2], m_a[2], m_b[2], m_o[2], m_c[2], m_s[2], m_h[2];

    bit log_en;
    int strobe_log[$];
    int ramen_exp[$];
    logic [7:0] rom [16];

    td4x_core #(.DW(4), .AW(4), .RESET_PC(3)) u_dut4 (
        .clk(clk), .reset(r4), .address(a4), .instr(i4), .instr_valid(v4),
        .in(in4), .out(o4), .out_strobe(s4), .halted(h4)
    );

    td4x_core #(.DW(8), .AW(4), .RESET_PC(0)) u_dut8 (
        .clk(clk), .reset(r8), .address(a8), .instr(i8), .instr_valid(v8),
        .in(in8), .out(o8), .out_strobe(s8), .halted(h8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-set level model of one core
    task automatic model_step(input int k, input int dw, input int rpc,
                              input logic r, input logic v, input int ins, input int inv);
        int mask, op, im, s;
        bit sets_c;
        mask = (1 << dw) - 1;
        if (r) begin
            m_pc[k] = rpc; m_a[k] = 0; m_b[k] = 0; m_o[k] = 0;
            m_c[k] = 0; m_s[k] = 0; m_h[k] = 0;
            return;
        end
        m_s[k] = 0;
        if (m_h[k] != 0 || !v) return;
        op = (ins >> dw) & 15;
        im = ins & mask;
        s = 0;
        sets_c = 1;
        case (op)
            0:  begin s = m_a[k] + im; m_a[k] = s & mask; end
            1:  begin s = m_b[k] + im; m_a[k] = s & mask; end
            2:  begin s = inv + im;    m_a[k] = s & mask; end
            3:  begin s = im;          m_a[k] = s; end
            4:  begin s = m_a[k] + im; m_b[k] = s & mask; end
            5:  begin s = m_b[k] + im; m_b[k] = s & mask; end
            6:  begin s = inv + im;    m_b[k] = s & mask; end
            7:  begin s = im;          m_b[k] = s; end
            9:  begin s = m_b[k] + im; m_o[k] = s & mask; m_s[k] = 1; end
            11: begin s = im;          m_o[k] = s; m_s[k] = 1; end
            default: sets_c = 0;
        endcase
        if (op == 8) begin
            m_h[k] = 1;
            return;
        end
        if (op == 15 || (op == 14 && m_c[k] == 0)) m_pc[k] = im % 16;
        else m_pc[k] = (m_pc[k] + 1) % 16;
        if (op == 14 || op == 15) begin s = im; sets_c = 1; end
        if (sets_c) m_c[k] = s >> dw;
    endtask

    task automatic compare();
        check("addr4",   32'(a4), m_pc[0]);
        check("out4",    32'(o4), m_o[0]);
        check("strobe4", 32'(s4), m_s[0]);
        check("halted4", 32'(h4), m_h[0]);
        check("addr8",   32'(a8), m_pc[1]);
        check("out8",    32'(o8), m_o[1]);
        check("strobe8", 32'(s8), m_s[1]);
        check("halted8", 32'(h8), m_h[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 3, r4, v4, int'(i4), int'(in4));
        model_step(1, 8, 0, r8, v8, int'(i8), int'(in8));
        @(negedge clk);
        compare();
        if (log_en && s4) strobe_log.push_back(int'(o4));
    endtask

    task automatic run4(input logic [7:0] ins);
        i4 = ins; v4 = 1'b1; tick(); v4 = 1'b0;
    endtask

    task automatic run8(input logic [11:0] ins);
        i8 = ins; v8 = 1'b1; tick(); v8 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; log_en = 0;
        r4 = 1'b1; v4 = 1'b0; i4 = '0; in4 = 4'b0101;
        r8 = 1'b1; v8 = 1'b0; i8 = '0; in8 = '0;

        // reset state
        tick();
        check("rst_addr4", 32'(a4), 3);
        check("rst_out4", 32'(o4), 0);
        check("rst_halt4", 32'(h4), 0);
        check("rst_strobe4", 32'(s4), 0);
        check("rst_addr8", 32'(a8), 0);
        r4 = 1'b0; r8 = 1'b0;

        // carry and JNC
        run4(8'h31); run4(8'h0F); run4(8'hE9);
        check("jnc_not_taken", 32'(a4), 6);
        run4(8'h00); run4(8'hE9);
        check("jnc_taken", 32'(a4), 9);
        run4(8'h40); run4(8'h90);
        check("out_b_a0", 32'(o4), 0);
        check("out_b_strobe", 32'(s4), 1);

        // OUT Im then 3-cycle stall
        run4(8'hBA);
        check("out_im", 32'(o4), 10);
        check("out_im_strobe", 32'(s4), 1);
        for (int n = 0; n < 3; n++) begin
            i4 = 8'($urandom); tick();
            check("stall_addr", 32'(a4), 12);
            check("stall_out", 32'(o4), 10);
            check("stall_strobe", 32'(s4), 0);
        end
        run4(8'hB3);
        check("b2b_strobe1", 32'(s4), 1);
        run4(8'hB5);
        check("b2b_strobe2", 32'(s4), 1);
        check("b2b_out", 32'(o4), 5);

        // HALT at address 5
        run4(8'hF5); run4(8'h80);
        check("halt_flag", 32'(h4), 1);
        check("halt_addr", 32'(a4), 5);
        for (int n = 0; n < 10; n++) begin
            i4 = 8'($urandom); v4 = 1'($urandom); tick();
        end
        check("halt_hold_addr", 32'(a4), 5);
        check("halt_hold_flag", 32'(h4), 1);
        r4 = 1'b1; v4 = 1'b1; i4 = 8'hFF; tick(); r4 = 1'b0; v4 = 1'b0;
        check("halt_rst_addr", 32'(a4), 3);
        check("halt_rst_flag", 32'(h4), 0);

        // PC wrap, NOP keeps carry
        run4(8'hFF); run4(8'hA0);
        check("pc_wrap", 32'(a4), 0);
        run4(8'h3F); run4(8'h01); run4(8'hC0); run4(8'hE0);
        check("nop_keeps_carry", 32'(a4), 4);
        run4(8'hD0); run4(8'hE0);
        check("jnc_after_clear", 32'(a4), 0);

        // DW=8 instance
        run8(12'h3F0); run8(12'h020); run8(12'hE05);
        check("w8_carry", 32'(a8), 3);
        run8(12'h400); run8(12'h900);
        check("w8_sum", 32'(o8), 8'h10);
        run8(12'hF37);
        check("w8_jmp_trunc", 32'(a8), 7);
        in8 = 8'h5A;
        run8(12'h201); run8(12'h400); run8(12'h900);
        check("w8_in_a", 32'(o8), 8'h5B);
        in8 = 8'hFF;
        run8(12'h601); run8(12'hE00);
        check("w8_in_b_carry", 32'(a8), 12);
        run8(12'hBC3);
        check("w8_out_im", 32'(o8), 8'hC3);
        run8(12'hF0F); run8(12'hA00);
        check("w8_pc_wrap", 32'(a8), 0);

        // ramen timer from address 0, stall in reset first
        rom = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        ramen_exp.push_back(7);
        ramen_exp.push_back(6);
        for (int n = 0; n < 16; n++) begin
            ramen_exp.push_back(0);
            ramen_exp.push_back(4);
        end
        ramen_exp.push_back(8);
        r4 = 1'b1; v4 = 1'b0; tick(); r4 = 1'b0;
        run4(8'hF0);
        log_en = 1;
        for (int n = 0; n < 400 && a4 != 4'd15; n++) begin
            i4 = rom[a4]; v4 = 1'b1; tick();
        end
        for (int n = 0; n < 4; n++) begin
            i4 = rom[a4]; v4 = 1'b1; tick();
        end
        v4 = 1'b0;
        log_en = 0;
        check("ramen_end_addr", 32'(a4), 15);
        check("ramen_out_count", 32'(strobe_log.size()), ramen_exp.size());
        for (int n = 0; n < ramen_exp.size(); n++) begin
            if (n < strobe_log.size()) check("ramen_out_seq", 32'(strobe_log[n]), ramen_exp[n]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
